// File: rtl/seq_pkg.sv
// seq_pkg: shared types and constants for the bit-stream sequence detector family.
package seq_pkg;

    localparam int SEQ_WORD_W = 8;

    typedef enum logic [0:0] {SER_IDLE, SER_SHIFT} ser_state_t;

endpackage

// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: parallel-to-serial front end feeding a detector's serial input.
// Words arrive over valid/ready; back-to-back words stream with no idle bit between them.
module seq_bit_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH     = SEQ_WORD_W,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             done,
    output logic             busy
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    ser_state_t       state, state_nxt;
    logic [WIDTH-1:0] sr, sr_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             last, accept;

    // The last-bit cycle doubles as a load slot so consecutive words abut.
    assign last       = (state == SER_SHIFT) && (cnt == LAST);
    assign load_ready = reset && ((state == SER_IDLE) || last);
    assign accept     = load_valid && load_ready;

    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        cnt_nxt   = cnt;
        if (accept) begin
            state_nxt = SER_SHIFT;
            sr_nxt    = load_data;
            cnt_nxt   = '0;
        end else if (last) begin
            state_nxt = SER_IDLE;
            sr_nxt    = '0;
            cnt_nxt   = '0;
        end else if (state == SER_SHIFT) begin
            sr_nxt  = MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
            cnt_nxt = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= SER_IDLE;
            sr    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            sr    <= sr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign busy      = (state == SER_SHIFT);
    assign ser_valid = busy;
    assign done      = last;
    assign ser_out   = busy ? (MSB_FIRST ? sr[WIDTH-1] : sr[0]) : IDLE_BIT;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// tb_seq_bit_serializer: table-driven and randomized checks of an MSB-first/idle-0
// instance and an LSB-first/idle-1 instance sharing clock, reset and load_valid.
module tb_seq_bit_serializer;
    import seq_pkg::*;

    localparam int W = SEQ_WORD_W;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         valid = 1'b0;
    logic [W-1:0] data_m = '0, data_l = '0;
    logic         ready_m, out_m, sval_m, done_m, busy_m;
    logic         ready_l, out_l, sval_l, done_l, busy_l;
    int           tests = 0, fails = 0;
    bit           q_m[$], q_l[$];
    bit           acc;

    typedef struct {
        logic [W-1:0] word;
        logic [W-1:0] msb_seq;
        logic [W-1:0] lsb_seq;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    seq_bit_serializer dut_m (
        .clk(clk), .reset(reset), .load_valid(valid), .load_data(data_m),
        .load_ready(ready_m), .ser_out(out_m), .ser_valid(sval_m), .done(done_m), .busy(busy_m)
    );

    seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_l (
        .clk(clk), .reset(reset), .load_valid(valid), .load_data(data_l),
        .load_ready(ready_l), .ser_out(out_l), .ser_valid(sval_l), .done(done_l), .busy(busy_l)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic em, input logic el,
                           input logic ev, input logic ed);
        chk({tag, " ser_out msb"}, out_m, em);
        chk({tag, " ser_out lsb"}, out_l, el);
        chk({tag, " ser_valid msb"}, sval_m, ev);
        chk({tag, " ser_valid lsb"}, sval_l, ev);
        chk({tag, " busy msb"}, busy_m, ev);
        chk({tag, " busy lsb"}, busy_l, ev);
        chk({tag, " done msb"}, done_m, ed);
        chk({tag, " done lsb"}, done_l, ed);
    endtask

    task automatic chk_ready(input string tag, input logic er);
        chk({tag, " load_ready msb"}, ready_m, er);
        chk({tag, " load_ready lsb"}, ready_l, er);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] w);
        valid  = 1'b1;
        data_m = w;
        data_l = w;
        chk_ready("pre-accept", 1'b1);
        step();
        valid = 1'b0;
    endtask

    task automatic chk_word(input string tag, input logic [W-1:0] ms, input logic [W-1:0] ls);
        for (int i = 0; i < W; i++) begin
            chk_out($sformatf("%s bit%0d", tag, i), ms[W-1-i], ls[W-1-i], 1'b1, i == W - 1);
            chk_ready($sformatf("%s bit%0d", tag, i), i == W - 1);
            step();
        end
        chk_out({tag, " idle"}, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic [2*W-1:0] bb_m, bb_l;
        vecs[0] = '{8'hA5, 8'b10100101, 8'b10100101};
        vecs[1] = '{8'h01, 8'b00000001, 8'b10000000};
        vecs[2] = '{8'h05, 8'b00000101, 8'b10100000};
        vecs[3] = '{8'h80, 8'b10000000, 8'b00000001};
        vecs[4] = '{8'h1E, 8'b00011110, 8'b01111000};
        vecs[5] = '{8'hC6, 8'b11000110, 8'b01100011};

        // reset asserted asynchronously before the first clock edge
        #1 reset = 1'b0;
        #1;
        chk_out("reset", 1'b0, 1'b1, 1'b0, 1'b0);
        chk_ready("reset", 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_ready("post-release", 1'b1);
        @(posedge clk);
        #1;

        foreach (vecs[v]) begin
            send_word(vecs[v].word);
            chk_word($sformatf("vec%0d", v), vecs[v].msb_seq, vecs[v].lsb_seq);
        end

        // back-to-back 05 then 80 with load_valid held
        bb_m = {8'b00000101, 8'b10000000};
        bb_l = {8'b10100000, 8'b00000001};
        send_word(8'h05);
        valid  = 1'b1;
        data_m = 8'h80;
        data_l = 8'h80;
        for (int i = 0; i < 2 * W; i++) begin
            chk_out($sformatf("b2b bit%0d", i), bb_m[2*W-1-i], bb_l[2*W-1-i], 1'b1,
                    (i == W - 1) || (i == 2 * W - 1));
            chk_ready($sformatf("b2b bit%0d", i), (i == W - 1) || (i == 2 * W - 1));
            step();
            if (i == W - 1) valid = 1'b0;
        end
        chk_out("b2b idle", 1'b0, 1'b1, 1'b0, 1'b0);

        // stall: FF offered in cycle 3 of A5 must wait for the done edge
        send_word(8'hA5);
        for (int i = 0; i < W; i++) begin
            if (i == 2) begin
                valid  = 1'b1;
                data_m = 8'hFF;
                data_l = 8'hFF;
            end
            chk_out($sformatf("stall bit%0d", i), vecs[0].msb_seq[W-1-i], vecs[0].lsb_seq[W-1-i],
                    1'b1, i == W - 1);
            chk_ready($sformatf("stall bit%0d", i), i == W - 1);
            step();
        end
        valid = 1'b0;
        chk_word("stall FF", 8'hFF, 8'hFF);

        // reset during bit 4 of A5
        send_word(8'hA5);
        step();
        step();
        step();
        #2 reset = 1'b0;
        #1;
        chk_out("midreset", 1'b0, 1'b1, 1'b0, 1'b0);
        chk_ready("midreset", 1'b0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("after reset %0d", i), 1'b0, 1'b1, 1'b0, 1'b0);
        end
        send_word(8'h1E);
        chk_word("post-reset 1E", vecs[4].msb_seq, vecs[4].lsb_seq);

        // randomized traffic against a bit-queue model
        q_m.delete();
        q_l.delete();
        acc = 1'b0;
        for (int c = 0; c < 600; c++) begin
            chk_out($sformatf("rnd c%0d", c), q_m.size() != 0 ? q_m[0] : 1'b0,
                    q_l.size() != 0 ? q_l[0] : 1'b1, q_m.size() != 0, q_m.size() == 1);
            chk_ready($sformatf("rnd c%0d", c), q_m.size() <= 1);
            if (!(valid && !acc)) begin
                valid  = ($urandom_range(0, 9) < 6);
                data_m = W'($urandom);
                data_l = W'($urandom);
            end
            if (c == 300) begin
                #2 reset = 1'b0;
                #1;
                chk_out("rnd reset", 1'b0, 1'b1, 1'b0, 1'b0);
                chk_ready("rnd reset", 1'b0);
                q_m.delete();
                q_l.delete();
                valid = 1'b0;
                acc   = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                step();
                continue;
            end
            acc = valid && (q_m.size() <= 1);
            step();
            if (q_m.size() != 0) void'(q_m.pop_front());
            if (q_l.size() != 0) void'(q_l.pop_front());
            if (acc) begin
                for (int i = 0; i < W; i++) begin
                    q_m.push_back(data_m[W-1-i]);
                    q_l.push_back(data_l[i]);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
